// File: rtl/expr_pkg.sv
// Shared definitions for the expression evaluator and the expression validator:
// ASCII codes of the legal characters, the parser state type and the default datapath width.
package expr_pkg;

    localparam int W_DEFAULT = 16;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    typedef enum logic [2:0] {
        IDLE,
        NUM,
        OPA,
        OPM,
        ERR
    } state_t;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier shared by the expression validator and evaluator.
// Maps one ASCII byte to digit/plus/star flags and the digit value.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output logic       is_digit,
    output logic       is_plus,
    output logic       is_star,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = (in >= CH_0) && (in <= CH_9);
        is_plus  = (in == CH_PLUS);
        is_star  = (in == CH_STAR);
        // The low nibble of '0'..'9' is the digit value itself.
        digit    = is_digit ? in[3:0] : 4'd0;
    end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for expressions of the form digit (op digit)*, op in {'+','*'}.
// Optional sticky overflow flag and port enabled by defining EXPR_EVAL_OVF_EN.
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         out,
    output logic [W-1:0] value,
    output logic         err
`ifdef EXPR_EVAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    state_t       state, state_n;
    logic [W-1:0] sum, sum_n;
    logic [W-1:0] term, term_n;
    logic [W-1:0] value_n;
    logic         err_n;

    logic         is_digit, is_plus, is_star;
    logic [3:0]   digit;
    logic [W-1:0] digit_w;

    expr_char_class u_char_class (
        .in       (in),
        .is_digit (is_digit),
        .is_plus  (is_plus),
        .is_star  (is_star),
        .digit    (digit)
    );

    assign digit_w = {{(W-4){1'b0}}, digit};
    assign out     = (state == NUM);

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            sum   <= '0;
            term  <= '0;
            value <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            sum   <= sum_n;
            term  <= term_n;
            value <= value_n;
            err   <= err_n;
        end
    end

    // NOTE: every output of this block is given a hold default first, so no latches are inferred.
    always_comb begin
        state_n = state;
        sum_n   = sum;
        term_n  = term;
        value_n = value;
        err_n   = err;
        if (in_valid) begin
            unique case (state)
                IDLE, OPA, OPM: begin
                    if (is_digit) begin
                        state_n = NUM;
                        term_n  = (state == OPM) ? term * digit_w : digit_w;
                        value_n = sum + term_n;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                NUM: begin
                    if (is_plus) begin
                        state_n = OPA;
                        sum_n   = sum + term;
                    end else if (is_star) begin
                        state_n = OPM;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                default: ;  // ERR absorbs everything until clr
            endcase
        end
    end

`ifdef EXPR_EVAL_OVF_EN
    logic           ovf_n;
    logic [2*W-1:0] prod_wide;
    logic [W:0]     value_wide;
    logic [W:0]     plus_wide;

    // Full-width copies of the datapath arithmetic; any carry or high product bit flags overflow.
    always_comb begin
        prod_wide  = {{W{1'b0}}, term} * {{(2*W-4){1'b0}}, digit};
        value_wide = {1'b0, sum} + {1'b0, term_n};
        plus_wide  = {1'b0, sum} + {1'b0, term};
        ovf_n      = ovf;
        if (in_valid) begin
            if (is_digit && (state == OPM) && ((prod_wide >> W) != '0))
                ovf_n = 1'b1;
            if (is_digit && (state inside {IDLE, OPA, OPM}) && value_wide[W])
                ovf_n = 1'b1;
            if (is_plus && (state == NUM) && plus_wide[W])
                ovf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) ovf <= 1'b0;
        else     ovf <= ovf_n;
    end
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: directed scenarios plus random character streams,
// compared against a prefix-parsing reference model with exact integer arithmetic.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in;
    logic        in_valid;
    logic        out;
    logic [15:0] value;
    logic        err;
`ifdef EXPR_EVAL_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // Every byte accepted since the last clr.
    byte unsigned hist[$];

    always #5 clk = ~clk;

    expr_eval #(.W(16)) dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .value    (value),
        .err      (err)
`ifdef EXPR_EVAL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    // Re-parses the whole accepted prefix from scratch with unbounded arithmetic.
    function automatic void model(output logic m_out, output logic m_err,
                                  output logic [15:0] m_val, output logic m_ovf);
        longint s = 0;
        longint t = 0;
        bit want_digit = 1'b1;
        bit mul = 1'b0;
        m_out = 1'b0;
        m_err = 1'b0;
        m_val = 16'd0;
        m_ovf = 1'b0;
        foreach (hist[i]) begin
            byte unsigned c;
            bit dig;
            c   = hist[i];
            dig = (c >= 8'h30) && (c <= 8'h39);
            if (m_err) break;
            if (want_digit && dig) begin
                t = mul ? t * longint'(c - 8'h30) : longint'(c - 8'h30);
                if (t > 65535 || s + t > 65535) m_ovf = 1'b1;
                m_val = 16'((s + t) % 65536);
                want_digit = 1'b0;
                m_out = 1'b1;
            end else if (!want_digit && (c == 8'h2B || c == 8'h2A)) begin
                if (c == 8'h2B) begin
                    s = s + t;
                    mul = 1'b0;
                end else begin
                    mul = 1'b1;
                end
                want_digit = 1'b1;
                m_out = 1'b0;
            end else begin
                m_err = 1'b1;
                m_out = 1'b0;
            end
        end
    endfunction

    task automatic check(input string tag);
        logic e_out, e_err, e_ovf;
        logic [15:0] e_val;
        model(e_out, e_err, e_val, e_ovf);
        checks++;
        assert (out === e_out) else begin
            failures++;
            $error("FAIL %s out got=%0b exp=%0b", tag, out, e_out);
        end
        checks++;
        assert (value === e_val) else begin
            failures++;
            $error("FAIL %s value got=%0d exp=%0d", tag, value, e_val);
        end
        checks++;
        assert (err === e_err) else begin
            failures++;
            $error("FAIL %s err got=%0b exp=%0b", tag, err, e_err);
        end
`ifdef EXPR_EVAL_OVF_EN
        checks++;
        assert (ovf === e_ovf) else begin
            failures++;
            $error("FAIL %s ovf got=%0b exp=%0b", tag, ovf, e_ovf);
        end
`endif
    endtask

    task automatic check_const(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input byte unsigned c, input string tag);
        @(negedge clk);
        in = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hist.push_back(c);
        check(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            check(tag);
        end
    endtask

    // Pulses clr between clock edges and checks the outputs cleared before any edge.
    task automatic do_clr(input string tag);
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        hist.delete();
        check(tag);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        in = 8'h00;
        in_valid = 1'b0;
        #1;
        check("reset");
        @(negedge clk);
        clr = 1'b0;
        idle(2, "post_reset");

        // 2+3*4
        send_str("2+", "r028a");
        check_const("r028_out2", {15'd0, out}, 16'd0);
        check_const("r028_val2", value, 16'd2);
        send_str("3*4", "r028b");
        check_const("r028_val", value, 16'd14);
        check_const("r028_out", {15'd0, out}, 16'd1);

        // 3* then idle
        do_clr("clr1");
        send_str("3*", "r029a");
        idle(10, "r029_idle");
        check_const("r029_val", value, 16'd3);
        check_const("r029_out", {15'd0, out}, 16'd0);

        // 2a5, clr, 7
        do_clr("clr2");
        send_str("2a", "r030a");
        check_const("r030_err", {15'd0, err}, 16'd1);
        send("5", "r030b");
        check_const("r030_val", value, 16'd2);
        do_clr("r030_clr");
        check_const("r030_clr_val", value, 16'd0);
        send("7", "r030c");
        check_const("r030_val7", value, 16'd7);

        // 9^6 wraps to 7153
        do_clr("clr3");
        send_str("9*9*9*9*9*9", "r031");
        check_const("r031_val", value, 16'd7153);
        check_const("r031_out", {15'd0, out}, 16'd1);

        // async clr mid 4+5, then leading operator
        do_clr("clr4");
        send_str("4+", "r032a");
        do_clr("r032_async");
        check_const("r032_zero", value, 16'd0);
        send_str("+1", "r032b");
        check_const("r032_err", {15'd0, err}, 16'd1);

        // 1+2+3*0, then leading '*'
        do_clr("clr5");
        send_str("1+2+3*0", "r033a");
        check_const("r033_val", value, 16'd3);
        do_clr("clr6");
        send("*", "r033b");
        check_const("r033_err", {15'd0, err}, 16'd1);

        // clr and a strobed byte on the same edge: byte is dropped
        do_clr("clr7");
        send_str("6+", "coin_pre");
        @(negedge clk);
        in = "5";
        in_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hist.delete();
        check("coin_clr");
        @(negedge clk);
        clr = 1'b0;
        idle(1, "coin_post");

        // random streams
        for (int n = 0; n < 40; n++) begin
            int len;
            do_clr("rnd_clr");
            len = $urandom_range(1, 11);
            for (int k = 0; k < len; k++) begin
                byte unsigned c;
                if ($urandom_range(0, 99) < 8)
                    c = byte'($urandom_range(0, 255));
                else if ((k % 2) == 0)
                    c = byte'(8'h30 + $urandom_range(0, 9));
                else
                    c = $urandom_range(0, 1) ? 8'h2B : 8'h2A;
                send(c, "rnd");
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "rnd_gap");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
